// File: rtl/inst_loader.sv
// Packs a byte stream into 32-bit words and writes them to instruction RAM from word 0, holding the core in reset.
// Latency: 4 byte transfers + 1 write cycle per word; done/err pulse 1 cycle after the final write, trailer or rejected start.
// Backpressure: byte_ready high only in RECV (and CHECK); optional trailer checksum under `CHECKSUM_EN.
module inst_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          byte_idx;
    logic [23:0]         word_buf;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                err_q;
    logic                start_ok;
    logic                last_word;
`ifdef CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    assign start_ok  = (word_count != '0) && (word_count <= DEPTH_W);
    assign last_word = ({1'b0, word_idx} == (count_q - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && start_ok) state_nxt = S_RECV;
            S_RECV:  if (byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
`ifdef CHECKSUM_EN
            S_WRITE: state_nxt = last_word ? S_CHECK : S_RECV;
            S_CHECK: if (byte_valid) state_nxt = (byte_data == sum_q) ? S_DONE : S_IDLE;
`else
            S_WRITE: state_nxt = last_word ? S_DONE : S_RECV;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
            S_WRITE: begin mem_we = 1'b1; busy = 1'b1; end
`ifdef CHECKSUM_EN
            S_CHECK: begin byte_ready = 1'b1; busy = 1'b1; end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign cpu_hold  = busy;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Address/data registers load on the 4th byte so they hold the last written word outside WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            count_q  <= word_count;
                            word_idx <= '0;
                            byte_idx <= '0;
`ifdef CHECKSUM_EN
                            sum_q    <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef CHECKSUM_EN
                        sum_q    <= sum_q + byte_data;
`endif
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                mem_wdata_q <= {byte_data, word_buf};
                                mem_addr_q  <= word_idx;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!last_word) word_idx <= word_idx + 1'b1;
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid && byte_data != sum_q) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected RAM writes queued as bytes are driven, popped on mem_we.
module tb_inst_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready, mem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, we_cnt = 0, cyc = 0, last_we_cyc = 0, done_cyc = 0;
    logic [36:0] exp_q[$];
    logic [36:0] e;
    logic [7:0]  sum_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (mem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                check("hold_on_we", {63'd0, cpu_hold}, 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_addr", {59'd0, mem_addr}, {59'd0, e[36:32]});
                    check("we_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", {62'd0, busy, cpu_hold}, 64'd0);
            end
            if (err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            n++;
            if (n > 40) begin
                check("ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        sum_acc = sum_acc + b;
    endtask

    task automatic send_word(input logic [4:0] addr, input logic [31:0] w,
                             input int max_gap, input logic poke);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int k = 0; k < g; k++) begin
                start = poke;
                word_count = '0;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(w[8*i +: 8]);
        end
        exp_q.push_back({addr, w});
    endtask

    task automatic start_load(input int n);
        word_count = n[ADDR_W:0];
        start = 1'b1;
        sum_acc = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_session;
`ifdef CHECKSUM_EN
        send_byte(sum_acc);
`endif
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, w0;
        sum_acc = '0;
        #2;
        check("rst_ctrl", {58'd0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
        check("rst_addr_data", {27'd0, mem_addr, mem_wdata}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Async reset in mid-clock during a partial session
        start_load(1);
        send_word(0, 32'hA5C3_0F11, 0, 1'b0);
        finish_session();
        check("t1_done", done_cnt, 1);
        start_load(1);
        send_byte(8'h99);
        send_byte(8'h77);
        #3;
        start = 1'($urandom);
        byte_valid = 1'b1;
        byte_data = 8'($urandom);
        word_count = 6'($urandom);
        rst = 1'b0;
        #1;
        check("t1_async_ctrl", {58'd0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
        check("t1_async_data", {27'd0, mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        check("t1_held_ctrl", {58'd0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_after_release", {62'd0, busy, cpu_hold}, 64'd0);
        @(posedge clk); #1;

        // Two-word back-to-back load
        d0 = done_cnt;
        start_load(2);
        check("t2_busy_hold", {62'd0, busy, cpu_hold}, 64'd3);
        send_word(0, 32'h1234_5678, 0, 1'b0);
        send_word(1, 32'hDEAD_BEEF, 0, 1'b0);
`ifndef CHECKSUM_EN
        finish_session();
        check("t2_done_latency", done_cyc, last_we_cyc + 1);
`else
        finish_session();
`endif
        check("t2_done", done_cnt, d0 + 1);

        // Rejected counts, then full-depth load
        e0 = err_cnt;
        w0 = we_cnt;
        start_load(0);
        check("t3_err_wc0", {62'd0, err, busy}, 64'd2);
        repeat (2) @(posedge clk); #1;
        start_load(33);
        check("t3_err_wc33", {62'd0, err, busy}, 64'd2);
        repeat (2) @(posedge clk); #1;
        check("t3_err_cnt", err_cnt, e0 + 2);
        check("t3_no_we", we_cnt, w0);
        d0 = done_cnt;
        start_load(32);
        for (int a = 0; a < DEPTH; a++) send_word(5'(a), $urandom, 0, 1'b0);
        finish_session();
        check("t3_full_done", done_cnt, d0 + 1);
        check("t3_full_we", we_cnt, w0 + 32);
        check("t3_last_addr", {59'd0, mem_addr}, 64'd31);

        // Gapped bytes with stray start pulses
        d0 = done_cnt;
        e0 = err_cnt;
        w0 = we_cnt;
        start_load(1);
        send_word(0, 32'hCAFE_F00D, 3, 1'b1);
        finish_session();
        check("t4_done", done_cnt, d0 + 1);
        check("t4_no_err", err_cnt, e0);
        check("t4_one_we", we_cnt, w0 + 1);

        // Reset after 6 bytes of a 2-word load
        d0 = done_cnt;
        w0 = we_cnt;
        start_load(2);
        send_word(0, 32'h0BAD_C0DE, 0, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst = 1'b0;
        #1;
        check("t5_busy_rst", {62'd0, busy, cpu_hold}, 64'd0);
        check("t5_q_empty", exp_q.size(), 0);
        check("t5_one_we", we_cnt, w0 + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        start_load(1);
        send_word(0, 32'h600D_F00D, 0, 1'b0);
        finish_session();
        check("t5_done", done_cnt, d0 + 1);

`ifdef CHECKSUM_EN
        // Trailer checksum match and mismatch
        d0 = done_cnt;
        e0 = err_cnt;
        start_load(1);
        send_word(0, 32'h0403_0201, 0, 1'b0);
        send_byte(8'h0A);
        repeat (3) @(posedge clk); #1;
        check("t6_good_done", done_cnt, d0 + 1);
        check("t6_good_err", err_cnt, e0);
        start_load(1);
        send_word(0, 32'h0403_0201, 0, 1'b0);
        send_byte(8'h0B);
        check("t6_bad_err_pulse", {63'd0, err}, 64'd1);
        repeat (3) @(posedge clk); #1;
        check("t6_bad_no_done", done_cnt, d0 + 1);
        check("t6_bad_err", err_cnt, e0 + 1);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
